zbus_master: RTL and testbench

Z80-style ZX-bus initiator: converts single-word requests from an internal host (USB or debug side) into cycle-accurate Z80 memory and I/O read/write bus cycles. It is the driving end of the ZX-bus that the CPLD's port/ROM-window decoder answers. Timing is built from T-states derived from `fclk`, with the Z80 automatic I/O wait state and optional `/WAIT` stretching.

---
 rtl/zbus_master.sv | 195 +++++++++++++++++++
 tb/tb_zbus_master.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/zbus_master.sv
// Z80-style ZX-bus initiator: turns single-word host requests into T-state timed MREQ/IORQ read/write cycles.
// Optional /WAIT stretching is compiled in with `define ZBUS_MASTER_WAIT_EN (adds the zwait_n port).
module zbus_master #(
    parameter int unsigned TSTATE_DIV = 4
) (
    input  logic        fclk,
    input  logic        rst,
    input  logic        req,
    input  logic        req_we,
    input  logic        req_io,
    input  logic [15:0] req_addr,
    input  logic [7:0]  req_wdata,
    output logic        busy,
    output logic        done,
    output logic [7:0]  rdata,
    output logic [15:0] za,
    output logic [7:0]  zd_out,
    output logic        zd_oe,
    input  logic [7:0]  zd_in,
    output logic        zmreq_n,
    output logic        ziorq_n,
    output logic        zrd_n,
    output logic        zwr_n
`ifdef ZBUS_MASTER_WAIT_EN
    ,
    input  logic        zwait_n
`endif
);

    localparam int unsigned CNT_W = 4;
    localparam int unsigned ADDR_W = 16;
    localparam int unsigned DATA_W = 8;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        T1   = 3'd1,
        T2   = 3'd2,
        TWA  = 3'd3,
        TW   = 3'd4,
        T3   = 3'd5
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                we_q, we_d;
    logic                io_q, io_d;
    logic [ADDR_W-1:0]   za_q, za_d;
    logic [DATA_W-1:0]   zd_out_q, zd_out_d;
    logic                zd_oe_q, zd_oe_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                zmreq_n_q, zmreq_n_d;
    logic                ziorq_n_q, ziorq_n_d;
    logic                zrd_n_q, zrd_n_d;
    logic                zwr_n_q, zwr_n_d;

    logic                last_c;
    logic                wait_c;
    state_t              check_c;

    // Last fclk of the current T-state.
    assign last_c = (cnt_q == CNT_W'(TSTATE_DIV - 1));

`ifdef ZBUS_MASTER_WAIT_EN
    assign wait_c = ~zwait_n;
`else
    assign wait_c = 1'b0;
`endif

    // Destination after T2 (memory), TWA or TW: stretch while the bus holds /WAIT low.
    assign check_c = wait_c ? TW : T3;

    always_ff @(posedge fclk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            we_q      <= 1'b0;
            io_q      <= 1'b0;
            za_q      <= '0;
            zd_out_q  <= '0;
            zd_oe_q   <= 1'b0;
            rdata_q   <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            zmreq_n_q <= 1'b1;
            ziorq_n_q <= 1'b1;
            zrd_n_q   <= 1'b1;
            zwr_n_q   <= 1'b1;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            we_q      <= we_d;
            io_q      <= io_d;
            za_q      <= za_d;
            zd_out_q  <= zd_out_d;
            zd_oe_q   <= zd_oe_d;
            rdata_q   <= rdata_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            zmreq_n_q <= zmreq_n_d;
            ziorq_n_q <= ziorq_n_d;
            zrd_n_q   <= zrd_n_d;
            zwr_n_q   <= zwr_n_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        we_d      = we_q;
        io_d      = io_q;
        za_d      = za_q;
        zd_out_d  = zd_out_q;
        zd_oe_d   = zd_oe_q;
        rdata_d   = rdata_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        zmreq_n_d = zmreq_n_q;
        ziorq_n_d = ziorq_n_q;
        zrd_n_d   = zrd_n_q;
        zwr_n_d   = zwr_n_q;

        if (state_q != IDLE) begin
            cnt_d = last_c ? '0 : cnt_q + CNT_W'(1);
        end

        case (state_q)
            IDLE: begin
                cnt_d   = '0;
                zd_oe_d = 1'b0;
                // The done cycle is also IDLE, so a held req chains straight into the next T1.
                if (req) begin
                    state_d = T1;
                    busy_d  = 1'b1;
                    we_d    = req_we;
                    io_d    = req_io;
                    za_d    = req_addr;
                    zd_oe_d = req_we;
                    if (req_we) begin
                        zd_out_d = req_wdata;
                    end
                end
            end
            T1: begin
                if (last_c) begin
                    state_d   = T2;
                    zmreq_n_d = io_q;
                    ziorq_n_d = ~io_q;
                    zrd_n_d   = we_q;
                    zwr_n_d   = ~we_q;
                end
            end
            T2: begin
                if (last_c) begin
                    state_d = io_q ? TWA : check_c;
                end
            end
            TWA, TW: begin
                if (last_c) begin
                    state_d = check_c;
                end
            end
            T3: begin
                if (last_c) begin
                    state_d   = IDLE;
                    busy_d    = 1'b0;
                    done_d    = 1'b1;
                    zmreq_n_d = 1'b1;
                    ziorq_n_d = 1'b1;
                    zrd_n_d   = 1'b1;
                    zwr_n_d   = 1'b1;
                    if (!we_q) begin
                        rdata_d = zd_in;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign rdata   = rdata_q;
    assign za      = za_q;
    assign zd_out  = zd_out_q;
    assign zd_oe   = zd_oe_q;
    assign zmreq_n = zmreq_n_q;
    assign ziorq_n = ziorq_n_q;
    assign zrd_n   = zrd_n_q;
    assign zwr_n   = zwr_n_q;

endmodule

// File: tb/tb_zbus_master.sv
// Self-checking bench for zbus_master: directed and randomized bus cycles against a T-state timing model.
module tb_zbus_master;

    localparam int D = 4;

    logic        fclk = 1'b0;
    logic        rst;
    logic        req;
    logic        req_we;
    logic        req_io;
    logic [15:0] req_addr;
    logic [7:0]  req_wdata;
    logic        busy;
    logic        done;
    logic [7:0]  rdata;
    logic [15:0] za;
    logic [7:0]  zd_out;
    logic        zd_oe;
    logic [7:0]  zd_in;
    logic        zmreq_n;
    logic        ziorq_n;
    logic        zrd_n;
    logic        zwr_n;
    logic        zwait_n;

    int checks = 0;
    int passed = 0;
    logic [7:0]  exp_rdata;
    logic [7:0]  exp_zd_out;

    zbus_master #(.TSTATE_DIV(D)) dut (
        .fclk(fclk),
        .rst(rst),
        .req(req),
        .req_we(req_we),
        .req_io(req_io),
        .req_addr(req_addr),
        .req_wdata(req_wdata),
        .busy(busy),
        .done(done),
        .rdata(rdata),
        .za(za),
        .zd_out(zd_out),
        .zd_oe(zd_oe),
        .zd_in(zd_in),
        .zmreq_n(zmreq_n),
        .ziorq_n(ziorq_n),
        .zrd_n(zrd_n),
        .zwr_n(zwr_n)
`ifdef ZBUS_MASTER_WAIT_EN
        ,
        .zwait_n(zwait_n)
`endif
    );

    always #5 fclk = ~fclk;

    task automatic start_req(input bit we, input bit io, input logic [15:0] a, input logic [7:0] wd);
        req       = 1'b1;
        req_we    = we;
        req_io    = io;
        req_addr  = a;
        req_wdata = wd;
    endtask

    // Runs one accepted cycle; step n is observed just after the n-th edge counted from the accept edge.
    task automatic do_cycle(input bit we, input bit io, input logic [15:0] addr, input logic [7:0] wd,
                            input logic [7:0] bd, input int nw, input int pulse_at, input bit chain,
                            input bit nwe, input bit nio, input logic [15:0] naddr, input logic [7:0] nwd);
        int tw;
        int lat;
        int c0;
        bit low;
        logic [3:0] es;
        logic [3:0] as;
`ifdef ZBUS_MASTER_WAIT_EN
        tw = nw;
`else
        tw = 0;
`endif
        lat = (io ? 4 : 3) * D + tw * D;
        c0  = (io ? 3 : 2) * D;
        if (we) exp_zd_out = wd;
        for (int n = 0; n <= lat; n++) begin
            @(posedge fclk);
            #1;
            if (n == 0) begin
                req     = 1'b0;
                zwait_n = (nw > 0) ? 1'b0 : 1'b1;
            end
            if (nw > 0 && n == c0 + (nw - 1) * D) zwait_n = 1'b1;
            zd_in = (n >= lat - D) ? bd : ~bd;
            if (n == pulse_at) begin
                req = 1'b1; req_we = ~we; req_io = ~io; req_addr = ~addr; req_wdata = ~wd;
            end else if (n == pulse_at + 1) begin
                req = 1'b0;
            end
            low = (n >= D) && (n < lat);
            es  = {~(low & ~io), ~(low & io), ~(low & ~we), ~(low & we)};
            as  = {zmreq_n, ziorq_n, zrd_n, zwr_n};
            if (n == lat && !we) exp_rdata = bd;
            checks++; if (as !== es) $display("FAIL strobes n=%0d got=%b exp=%b", n, as, es); else passed++;
            checks++; if ((as[3] | as[2]) !== 1'b1 || (as[1] | as[0]) !== 1'b1)
                $display("FAIL strobe_excl n=%0d got=%b exp=no pair low", n, as); else passed++;
            checks++; if (done !== (n == lat)) $display("FAIL done n=%0d got=%b exp=%b", n, done, n == lat); else passed++;
            checks++; if (busy !== (n < lat)) $display("FAIL busy n=%0d got=%b exp=%b", n, busy, n < lat); else passed++;
            checks++; if (za !== addr) $display("FAIL za n=%0d got=%h exp=%h", n, za, addr); else passed++;
            checks++; if (zd_oe !== we) $display("FAIL zd_oe n=%0d got=%b exp=%b", n, zd_oe, we); else passed++;
            checks++; if (zd_out !== exp_zd_out) $display("FAIL zd_out n=%0d got=%h exp=%h", n, zd_out, exp_zd_out); else passed++;
            checks++; if (rdata !== exp_rdata) $display("FAIL rdata n=%0d got=%h exp=%h", n, rdata, exp_rdata); else passed++;
            if (n == lat && chain) start_req(nwe, nio, naddr, nwd);
        end
        if (!chain) begin
            @(posedge fclk);
            #1;
            as = {zmreq_n, ziorq_n, zrd_n, zwr_n};
            checks++; if ({zd_oe, busy, done} !== 3'b000) $display("FAIL post_cycle oe/busy/done got=%b exp=000", {zd_oe, busy, done}); else passed++;
            checks++; if (as !== 4'hF) $display("FAIL post_strobes got=%b exp=1111", as); else passed++;
            checks++; if (za !== addr) $display("FAIL post_za got=%h exp=%h", za, addr); else passed++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; req = 1'b0; req_we = 1'b0; req_io = 1'b0; req_addr = '0; req_wdata = '0;
        zd_in = '0; zwait_n = 1'b1;
        exp_rdata = '0; exp_zd_out = '0;
        #1;
        checks++; if ({za, zd_out, zd_oe} !== 25'd0) $display("FAIL reset_bus got=%h exp=0", {za, zd_out, zd_oe}); else passed++;
        checks++; if ({zmreq_n, ziorq_n, zrd_n, zwr_n} !== 4'hF) $display("FAIL reset_strobes got=%b exp=1111", {zmreq_n, ziorq_n, zrd_n, zwr_n}); else passed++;
        checks++; if ({busy, done, rdata} !== 10'd0) $display("FAIL reset_status got=%h exp=0", {busy, done, rdata}); else passed++;
        repeat (3) @(posedge fclk);
        #1 rst = 1'b0;
        @(posedge fclk);
        #1;
        checks++; if (busy !== 1'b0) $display("FAIL reset_idle busy got=%b exp=0", busy); else passed++;
    endtask

    task automatic test_mem_read();
        start_req(1'b0, 1'b0, 16'h4000, 8'h00);
        do_cycle(1'b0, 1'b0, 16'h4000, 8'h00, 8'h5A, 0, -1, 1'b0, 1'b0, 1'b0, 16'h0, 8'h0);
    endtask

    task automatic test_io_write();
        start_req(1'b1, 1'b1, 16'h80AB, 8'hC3);
        do_cycle(1'b1, 1'b1, 16'h80AB, 8'hC3, 8'h00, 0, -1, 1'b0, 1'b0, 1'b0, 16'h0, 8'h0);
    endtask

    task automatic test_wait();
        start_req(1'b0, 1'b1, 16'h00FE, 8'h00);
        do_cycle(1'b0, 1'b1, 16'h00FE, 8'h00, 8'h3C, 2, -1, 1'b0, 1'b0, 1'b0, 16'h0, 8'h0);
        start_req(1'b1, 1'b0, 16'h2222, 8'h99);
        do_cycle(1'b1, 1'b0, 16'h2222, 8'h99, 8'h00, 1, -1, 1'b0, 1'b0, 1'b0, 16'h0, 8'h0);
    endtask

    task automatic test_back_to_back();
        start_req(1'b1, 1'b0, 16'h1234, 8'h11);
        do_cycle(1'b1, 1'b0, 16'h1234, 8'h11, 8'h00, 0, -1, 1'b1, 1'b1, 1'b0, 16'h5678, 8'h22);
        do_cycle(1'b1, 1'b0, 16'h5678, 8'h22, 8'h00, 0, -1, 1'b1, 1'b0, 1'b1, 16'h0042, 8'h00);
        do_cycle(1'b0, 1'b1, 16'h0042, 8'h00, 8'hE7, 0, -1, 1'b0, 1'b0, 1'b0, 16'h0, 8'h0);
    endtask

    task automatic test_ignored_req();
        start_req(1'b1, 1'b0, 16'hBEEF, 8'h77);
        do_cycle(1'b1, 1'b0, 16'hBEEF, 8'h77, 8'h00, 0, 5, 1'b0, 1'b0, 1'b0, 16'h0, 8'h0);
        start_req(1'b0, 1'b1, 16'h0F0F, 8'h00);
        do_cycle(1'b0, 1'b1, 16'h0F0F, 8'h00, 8'h81, 0, 4 * D - 1, 1'b0, 1'b0, 1'b0, 16'h0, 8'h0);
        for (int k = 0; k < 3; k++) begin
            @(posedge fclk);
            #1;
            checks++; if ({busy, za} !== {1'b0, 16'h0F0F}) $display("FAIL ignored_extra k=%0d got=%h exp=%h", k, {busy, za}, {1'b0, 16'h0F0F}); else passed++;
            checks++; if (zd_out !== 8'h77) $display("FAIL ignored_wdata k=%0d got=%h exp=77", k, zd_out); else passed++;
        end
    endtask

    task automatic test_random();
        bit cw, cio, nwe, nio, chain, pend;
        logic [15:0] ca, na;
        logic [7:0]  cwd, nwd, bd;
        int nw;
        pend = 1'b0;
        cw = 1'($urandom); cio = 1'($urandom); ca = 16'($urandom); cwd = 8'($urandom);
        for (int i = 0; i < 24; i++) begin
            if (!pend) start_req(cw, cio, ca, cwd);
            nwe = 1'($urandom); nio = 1'($urandom); na = 16'($urandom); nwd = 8'($urandom);
            bd = 8'($urandom);
            nw = int'($urandom_range(0, 3));
            chain = ($urandom_range(0, 2) == 0) && (i < 23);
            do_cycle(cw, cio, ca, cwd, bd, nw, -1, chain, nwe, nio, na, nwd);
            cw = nwe; cio = nio; ca = na; cwd = nwd; pend = chain;
        end
    endtask

    task automatic test_reset_mid();
        start_req(1'b0, 1'b0, 16'h3000, 8'h00);
        do_cycle(1'b0, 1'b0, 16'h3000, 8'h00, 8'hA5, 0, -1, 1'b0, 1'b0, 1'b0, 16'h0, 8'h0);
        start_req(1'b0, 1'b1, 16'h00FB, 8'h00);
        for (int n = 0; n <= D + 1; n++) begin
            @(posedge fclk);
            #1;
            if (n == 0) req = 1'b0;
        end
        checks++; if ({ziorq_n, zrd_n} !== 2'b00) $display("FAIL mid_pre_strobes got=%b exp=00", {ziorq_n, zrd_n}); else passed++;
        rst = 1'b1;
        #1;
        exp_rdata = '0; exp_zd_out = '0;
        checks++; if ({zmreq_n, ziorq_n, zrd_n, zwr_n} !== 4'hF) $display("FAIL mid_strobes got=%b exp=1111", {zmreq_n, ziorq_n, zrd_n, zwr_n}); else passed++;
        checks++; if ({zd_oe, busy, done} !== 3'b000) $display("FAIL mid_status got=%b exp=000", {zd_oe, busy, done}); else passed++;
        checks++; if (rdata !== 8'h00) $display("FAIL mid_rdata got=%h exp=00", rdata); else passed++;
        checks++; if ({za, zd_out} !== 24'd0) $display("FAIL mid_bus got=%h exp=0", {za, zd_out}); else passed++;
        repeat (2) @(posedge fclk);
        #1 rst = 1'b0;
        for (int k = 0; k < 4 * D; k++) begin
            @(posedge fclk);
            #1;
            checks++; if ({done, busy} !== 2'b00) $display("FAIL mid_after k=%0d got=%b exp=00", k, {done, busy}); else passed++;
        end
    endtask

    initial begin
        test_reset();
        test_mem_read();
        test_io_write();
        test_wait();
        test_back_to_back();
        test_ignored_req();
        test_random();
        test_reset_mid();
        test_mem_read();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
